// File: rtl/mem_access_unit.sv
// mem_access_unit
//   Load/store stage sitting behind the execution unit. Accepts one memory op
//   per handshake, issues it on a req/gnt/rvalid data-memory port, and returns
//   load data to writeback as a one-cycle pulse. Misaligned accesses are
//   rejected with a one-cycle error pulse and never reach memory.
//
// Ports
//   clk_i, rst_i                 clock, synchronous active-high reset
//   req_valid_i / req_ready_o    op handshake from execution (ready only in idle)
//   is_store_i, addr_i,
//   wdata_i, rd_addr_i           op payload: kind, byte address, store data, dest reg
//   mem_req_o, mem_we_o,
//   mem_addr_o, mem_wdata_o      memory request (address word-aligned)
//   mem_gnt_i                    memory accepted the request
//   mem_rvalid_i, mem_rdata_i    memory response (load data or store ack)
//   wb_valid_o, wb_rd_addr_o,
//   wb_data_o                    load writeback pulse, data/index hold between pulses
//   err_o                        misaligned-access pulse
//   busy_o                       op in flight
module mem_access_unit #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned REG_ADDR_WIDTH = 5
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  logic                      is_store_i,
    input  logic [ADDR_WIDTH-1:0]     addr_i,
    input  logic [DATA_WIDTH-1:0]     wdata_i,
    input  logic [REG_ADDR_WIDTH-1:0] rd_addr_i,
    output logic                      mem_req_o,
    output logic                      mem_we_o,
    output logic [ADDR_WIDTH-1:0]     mem_addr_o,
    output logic [DATA_WIDTH-1:0]     mem_wdata_o,
    input  logic                      mem_gnt_i,
    input  logic                      mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0]     mem_rdata_i,
    output logic                      wb_valid_o,
    output logic [REG_ADDR_WIDTH-1:0] wb_rd_addr_o,
    output logic [DATA_WIDTH-1:0]     wb_data_o,
    output logic                      err_o,
    output logic                      busy_o
);

    // Byte-offset bits within a data word; a mask keeps this valid even for
    // DATA_WIDTH == 8 where there are no offset bits at all.
    localparam logic [ADDR_WIDTH-1:0] AlignMask = ADDR_WIDTH'(DATA_WIDTH / 8 - 1);

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWait,
        StResp
    } state_e;

    state_e r_state;
    state_e w_state_next;

    logic                      r_is_store;
    logic [ADDR_WIDTH-1:0]     r_addr;
    logic [DATA_WIDTH-1:0]     r_wdata;
    logic [REG_ADDR_WIDTH-1:0] r_rd_addr;

    logic                      r_wb_valid;
    logic [REG_ADDR_WIDTH-1:0] r_wb_rd_addr;
    logic [DATA_WIDTH-1:0]     r_wb_data;
    logic                      r_err;

    logic w_handshake;
    logic w_misaligned;
    logic w_load_done;

    assign w_handshake  = req_valid_i & req_ready_o;
    assign w_misaligned = |(addr_i & AlignMask);
    // rvalid only counts in WAIT: early or stale responses are dropped.
    assign w_load_done  = (r_state == StWait) & mem_rvalid_i & ~r_is_store;

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle: begin
                if (w_handshake) begin
                    w_state_next = w_misaligned ? StResp : StReq;
                end
            end
            StReq: begin
                if (mem_gnt_i) begin
                    w_state_next = StWait;
                end
            end
            StWait: begin
                if (mem_rvalid_i) begin
                    w_state_next = StResp;
                end
            end
            StResp:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // Outputs decoded from state; memory outputs are zero outside REQ.
    always_comb begin
        req_ready_o = 1'b0;
        busy_o      = 1'b1;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        case (r_state)
            StIdle: begin
                req_ready_o = 1'b1;
                busy_o      = 1'b0;
            end
            StReq: begin
                mem_req_o   = 1'b1;
                mem_we_o    = r_is_store;
                mem_addr_o  = r_addr & ~AlignMask;
                mem_wdata_o = r_wdata;
            end
            default: ;
        endcase
    end

    // Captured op
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_is_store <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rd_addr  <= '0;
        end else if (w_handshake) begin
            r_is_store <= is_store_i;
            r_addr     <= addr_i;
            r_wdata    <= wdata_i;
            r_rd_addr  <= rd_addr_i;
        end
    end

    // Registered result pulses; both land in the RESP cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wb_valid   <= 1'b0;
            r_err        <= 1'b0;
            r_wb_data    <= '0;
            r_wb_rd_addr <= '0;
        end else begin
            r_wb_valid <= w_load_done;
            r_err      <= w_handshake & w_misaligned;
            if (w_load_done) begin
                r_wb_data    <= mem_rdata_i;
                r_wb_rd_addr <= r_rd_addr;
            end
        end
    end

    assign wb_valid_o   = r_wb_valid;
    assign wb_rd_addr_o = r_wb_rd_addr;
    assign wb_data_o    = r_wb_data;
    assign err_o        = r_err;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit
//   Directed tests plus a short randomised load/store loop. Expected writeback
//   and error results are queued when an op is driven and matched by a monitor
//   when the unit produces its pulse.
module tb_mem_access_unit;

    logic        clk_i;
    logic        rst_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        is_store_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic [4:0]  rd_addr_i;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        wb_valid_o;
    logic [4:0]  wb_rd_addr_o;
    logic [31:0] wb_data_o;
    logic        err_o;
    logic        busy_o;

    mem_access_unit #(
        .DATA_WIDTH    (32),
        .ADDR_WIDTH    (32),
        .REG_ADDR_WIDTH(5)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .is_store_i  (is_store_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .rd_addr_i   (rd_addr_i),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_gnt_i   (mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i),
        .mem_rdata_i (mem_rdata_i),
        .wb_valid_o  (wb_valid_o),
        .wb_rd_addr_o(wb_rd_addr_o),
        .wb_data_o   (wb_data_o),
        .err_o       (err_o),
        .busy_o      (busy_o)
    );

    typedef struct packed {
        logic        is_err;
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    exp_t sb_q[$];
    int   wb_cyc_q[$];
    int   n_checks;
    int   n_errors;
    int   cyc;

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk_i) cyc <= cyc + 1;

    // Scoreboard monitor, samples mid-cycle.
    always @(negedge clk_i) begin
        if (!rst_i) begin
            if (wb_valid_o && err_o) begin
                check("wb_err_exclusive", 1, 0);
            end else if (wb_valid_o || err_o) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_pulse", {wb_valid_o, err_o}, 2'b00);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("pulse_kind", err_o, e.is_err);
                    if (wb_valid_o) begin
                        check("sb_wb_rd", wb_rd_addr_o, e.rd);
                        check("sb_wb_data", wb_data_o, e.data);
                        wb_cyc_q.push_back(cyc);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push_load(input logic [4:0] rd, input logic [31:0] data);
        exp_t e;
        e.is_err = 1'b0;
        e.rd     = rd;
        e.data   = data;
        sb_q.push_back(e);
    endtask

    // Generic op with bounded wait for ready; ends in the RESP cycle.
    task automatic do_op(input logic st, input logic [31:0] a, input logic [31:0] wd,
                         input logic [4:0] rd, input logic [31:0] rdat,
                         input int gnt_dly, input int rv_dly);
        int t;
        req_valid_i = 1'b1;
        is_store_i  = st;
        addr_i      = a;
        wdata_i     = wd;
        rd_addr_i   = rd;
        t = 0;
        while (!req_ready_o && t < 20) begin
            step();
            t++;
        end
        check("op_ready", req_ready_o, 1);
        if (!st) push_load(rd, rdat);
        step();
        req_valid_i = 1'b0;
        check("op_mem_addr", mem_addr_o, a);
        check("op_mem_we", mem_we_o, st);
        repeat (gnt_dly) step();
        mem_gnt_i = 1'b1;
        step();
        mem_gnt_i = 1'b0;
        repeat (rv_dly) step();
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = rdat;
        step();
        mem_rvalid_i = 1'b0;
    endtask

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        cyc          = 0;
        rst_i        = 1'b1;
        req_valid_i  = 1'b0;
        is_store_i   = 1'b0;
        addr_i       = '0;
        wdata_i      = '0;
        rd_addr_i    = '0;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;
        step();
        step();
        check("rst_ready", req_ready_o, 1);
        check("rst_busy", busy_o, 0);
        check("rst_mem_req", mem_req_o, 0);
        check("rst_wb_valid", wb_valid_o, 0);
        check("rst_err", err_o, 0);
        check("rst_wb_data", wb_data_o, 0);
        rst_i = 1'b0;
        step();

        // Aligned load, grant immediately, rvalid next cycle
        req_valid_i = 1'b1;
        addr_i      = 32'h0000_0010;
        rd_addr_i   = 5'd5;
        is_store_i  = 1'b0;
        check("ld_ready", req_ready_o, 1);
        push_load(5'd5, 32'hDEAD_BEEF);
        step();
        req_valid_i = 1'b0;
        check("ld_mem_req", mem_req_o, 1);
        check("ld_mem_addr", mem_addr_o, 32'h10);
        check("ld_mem_we", mem_we_o, 0);
        check("ld_busy", busy_o, 1);
        mem_gnt_i = 1'b1;
        step();
        mem_gnt_i = 1'b0;
        check("ld_wait_req", mem_req_o, 0);
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'hDEAD_BEEF;
        step();
        mem_rvalid_i = 1'b0;
        check("ld_wb_valid", wb_valid_o, 1);
        check("ld_wb_rd", wb_rd_addr_o, 5);
        check("ld_wb_data", wb_data_o, 32'hDEAD_BEEF);
        check("ld_resp_ready", req_ready_o, 0);
        step();
        check("ld_wb_pulse_end", wb_valid_o, 0);
        check("ld_idle_ready", req_ready_o, 1);
        check("ld_wb_hold", wb_data_o, 32'hDEAD_BEEF);

        // Store with grant withheld three cycles
        req_valid_i = 1'b1;
        is_store_i  = 1'b1;
        addr_i      = 32'h20;
        wdata_i     = 32'h1234_5678;
        step();
        req_valid_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("st_mem_req", mem_req_o, 1);
            check("st_mem_we", mem_we_o, 1);
            check("st_mem_addr", mem_addr_o, 32'h20);
            check("st_mem_wdata", mem_wdata_o, 32'h1234_5678);
            if (i == 3) mem_gnt_i = 1'b1;
            step();
        end
        mem_gnt_i = 1'b0;
        check("st_wait_req", mem_req_o, 0);
        mem_rvalid_i = 1'b1;
        step();
        mem_rvalid_i = 1'b0;
        check("st_no_wb", wb_valid_o, 0);
        check("st_resp_busy", busy_o, 1);
        step();
        check("st_ready_back", req_ready_o, 1);
        check("st_wb_hold", wb_data_o, 32'hDEAD_BEEF);

        // Misaligned load
        req_valid_i = 1'b1;
        is_store_i  = 1'b0;
        addr_i      = 32'h0000_0013;
        rd_addr_i   = 5'd7;
        begin
            exp_t e;
            e.is_err = 1'b1;
            e.rd     = '0;
            e.data   = '0;
            sb_q.push_back(e);
        end
        step();
        req_valid_i = 1'b0;
        check("mis_err", err_o, 1);
        check("mis_mem_req", mem_req_o, 0);
        check("mis_wb_valid", wb_valid_o, 0);
        check("mis_ready_n1", req_ready_o, 0);
        step();
        check("mis_ready_n2", req_ready_o, 1);
        check("mis_err_end", err_o, 0);
        check("mis_mem_req2", mem_req_o, 0);

        // Back-pressure: second op held on req_valid during the first
        req_valid_i = 1'b1;
        addr_i      = 32'h40;
        rd_addr_i   = 5'd3;
        push_load(5'd3, 32'h111);
        step();
        addr_i    = 32'h80;
        rd_addr_i = 5'd4;
        check("bp_ready_req", req_ready_o, 0);
        check("bp_addr_first", mem_addr_o, 32'h40);
        mem_gnt_i = 1'b1;
        step();
        mem_gnt_i = 1'b0;
        check("bp_ready_wait", req_ready_o, 0);
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h111;
        step();
        mem_rvalid_i = 1'b0;
        check("bp_ready_resp", req_ready_o, 0);
        check("bp_wb_first", wb_valid_o, 1);
        step();
        check("bp_ready_idle", req_ready_o, 1);
        push_load(5'd4, 32'h222);
        step();
        req_valid_i = 1'b0;
        check("bp_mem_req2", mem_req_o, 1);
        check("bp_addr_second", mem_addr_o, 32'h80);
        mem_gnt_i = 1'b1;
        step();
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h222;
        step();
        mem_rvalid_i = 1'b0;
        step();

        // Reset while waiting for rvalid
        req_valid_i = 1'b1;
        addr_i      = 32'h50;
        rd_addr_i   = 5'd9;
        step();
        req_valid_i = 1'b0;
        mem_gnt_i   = 1'b1;
        step();
        mem_gnt_i = 1'b0;
        check("rm_in_wait", busy_o, 1);
        rst_i = 1'b1;
        step();
        rst_i        = 1'b0;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'hBAD0_BAD0;
        check("rm_busy", busy_o, 0);
        check("rm_ready", req_ready_o, 1);
        check("rm_mem_req", mem_req_o, 0);
        check("rm_mem_we", mem_we_o, 0);
        check("rm_mem_addr", mem_addr_o, 0);
        check("rm_mem_wdata", mem_wdata_o, 0);
        check("rm_wb_valid", wb_valid_o, 0);
        step();
        mem_rvalid_i = 1'b0;
        check("rm_no_wb", wb_valid_o, 0);
        check("rm_busy2", busy_o, 0);
        step();

        // Back-to-back loads
        wb_cyc_q.delete();
        do_op(1'b0, 32'h100, 32'h0, 5'd1, 32'hA, 0, 0);
        do_op(1'b0, 32'h104, 32'h0, 5'd2, 32'hB, 0, 0);
        step();
        step();
        check("b2b_pulses", wb_cyc_q.size(), 2);
        if (wb_cyc_q.size() == 2) begin
            check("b2b_spacing_ge4", (wb_cyc_q[1] - wb_cyc_q[0]) >= 4, 1);
        end

        // Randomised ops with random grant/response delays
        for (int i = 0; i < 8; i++) begin
            logic        st;
            logic [31:0] a;
            st = 1'($urandom_range(0, 1));
            a  = {$urandom_range(0, 255), 2'b00};
            do_op(st, a, $urandom, 5'($urandom_range(0, 31)), $urandom,
                  $urandom_range(0, 3), $urandom_range(0, 3));
        end
        step();
        step();
        check("sb_empty", sb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
